// File: rtl/csr_access_unit.sv
// csr_access_unit: executes SYSTEM-opcode CSR instructions against an external CSR set.
// Flow: IDLE accepts an instruction. CHECK presents the CSR address and snapshots the read data.
// WB writes the snapshot to rd and waits for RD_ACK. TRAP flags an illegal instruction.
// Optional build macro: CSR_ACCESS_CHECK_EN. When it is defined, the unit also traps any CSR
// write and any address outside the implemented read-only counter/ID set. When it is not
// defined, only the opcode and funct3 checks apply.
// CORE_ID is carried for trace only and has no functional effect.
module csr_access_unit #(
  parameter logic [31:0] CORE_ID = 32'd0
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic [31:0] INSTR,
  output logic [11:0] CSR_ADR,
  input  logic [31:0] CSR_DATA,
  output logic        RD_WE,
  output logic [4:0]  RD_ADR,
  output logic [31:0] RD_DATA,
  input  logic        RD_ACK,
  output logic        INSTR_DONE,
  output logic        ILLEGAL
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    WB    = 2'd2,
    TRAP  = 2'd3
  } state_e;

  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] snap_q, snap_d;

  // Fields of the latched instruction
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rd;
  logic [11:0] csr_adr;

  assign opcode  = instr_q[6:0];
  assign rd      = instr_q[11:7];
  assign funct3  = instr_q[14:12];
  assign rs1     = instr_q[19:15];
  assign csr_adr = instr_q[31:20];

  logic illegal_base;
  logic write_intent;
  logic illegal;
  logic wb_last;

  // Decode legality and write intent of the latched instruction
  always_comb begin
    // funct3 000 (ECALL/EBREAK/xRET) and 100 (reserved) are not CSR accesses.
    illegal_base = (opcode != OPC_SYSTEM) || (funct3[1:0] == 2'b00);
    // CSRRW/CSRRWI always write; the set/clear forms write only with a non-zero source.
    write_intent = (funct3[1:0] == 2'b01) || (funct3[1] && (rs1 != 5'd0));
`ifdef CSR_ACCESS_CHECK_EN
    case (csr_adr)
      12'hC00, 12'hC01, 12'hC02,
      12'hC80, 12'hC81, 12'hC82,
      12'hF14: illegal = illegal_base || write_intent;
      default: illegal = 1'b1;
    endcase
`else
    illegal = illegal_base;
`endif
  end

  // In WB the transaction ends on RD_ACK, or immediately when rd is x0.
  assign wb_last = (state_q == WB) && ((rd == 5'd0) || RD_ACK);

  // Next-state and datapath update for the access sequence
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    instr_d = instr_q;
    snap_d  = snap_q;
    case (state_q)
      IDLE: begin
        if (REQ_VALID) begin
          instr_d = INSTR;
          state_d = CHECK;
        end
      end
      CHECK: begin
        snap_d  = CSR_DATA;
        state_d = illegal ? TRAP : WB;
      end
      WB: begin
        if (wb_last) state_d = IDLE;
      end
      TRAP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any in-flight instruction at once
  always_ff @(posedge CLK or posedge RES) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (RES) begin
      state_q <= IDLE;
      instr_q <= '0;
      snap_q  <= '0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      snap_q  <= snap_d;
    end
  end

  // Outputs are decoded from registered state. INSTR_DONE also follows RD_ACK so the
  // retire pulse lands in the acknowledging cycle.
  assign REQ_READY  = (state_q == IDLE);
  assign CSR_ADR    = csr_adr;
  assign RD_WE      = (state_q == WB) && (rd != 5'd0);
  assign RD_ADR     = (state_q == WB) ? rd : 5'd0;
  assign RD_DATA    = (state_q == WB) ? snap_q : 32'd0;
  assign INSTR_DONE = wb_last;
  assign ILLEGAL    = (state_q == TRAP);

  // Trace-only parameter and build-dependent decode terms
  logic unused_ok;
  assign unused_ok = ^{CORE_ID, write_intent};

endmodule

// File: tb/tb_csr_access_unit.sv
// Directed testbench for csr_access_unit. It includes a small CSR set model
// (cycle/time/instret/hart ID). Expectations follow the CSR_ACCESS_CHECK_EN build setting.
module tb_csr_access_unit;

  logic        CLK;
  logic        RES;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [31:0] INSTR;
  logic [11:0] CSR_ADR;
  logic [31:0] CSR_DATA;
  logic        RD_WE;
  logic [4:0]  RD_ADR;
  logic [31:0] RD_DATA;
  logic        RD_ACK;
  logic        INSTR_DONE;
  logic        ILLEGAL;

  int tests = 0;
  int fails = 0;

  logic [31:0] cycle_val;
  logic [31:0] time_val;
  logic [31:0] instret_val;

  csr_access_unit #(.CORE_ID(32'd3)) dut (
    .CLK       (CLK),
    .RES       (RES),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .INSTR     (INSTR),
    .CSR_ADR   (CSR_ADR),
    .CSR_DATA  (CSR_DATA),
    .RD_WE     (RD_WE),
    .RD_ADR    (RD_ADR),
    .RD_DATA   (RD_DATA),
    .RD_ACK    (RD_ACK),
    .INSTR_DONE(INSTR_DONE),
    .ILLEGAL   (ILLEGAL)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // CSR set model: combinational read by address
  always_comb begin
    case (CSR_ADR)
      12'hC00: CSR_DATA = cycle_val;
      12'hC01: CSR_DATA = time_val;
      12'hC02: CSR_DATA = instret_val;
      12'hF14: CSR_DATA = 32'd3;
      default: CSR_DATA = 32'd0;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accept, CHECK, ack_wait WB cycles without ack, then the retiring WB cycle.
  task automatic run_read(input logic [31:0] instr, input int ack_wait,
                          input logic [11:0] exp_adr, input logic [4:0] exp_rd,
                          input logic [31:0] exp_data);
    @(negedge CLK); REQ_VALID = 1'b1; INSTR = instr; RD_ACK = 1'b0;
    #1 check("ready_in_idle", REQ_READY, 1);
    @(negedge CLK); REQ_VALID = 1'b0;
    #1 check("ready_in_check", REQ_READY, 0);
    check("csr_adr_in_check", CSR_ADR, exp_adr);
    check("no_done_in_check", INSTR_DONE, 0);
    for (int i = 0; i < ack_wait; i++) begin
      @(negedge CLK); RD_ACK = 1'b0; cycle_val = cycle_val + 32'd7;
      #1 check("wb_we_hold", RD_WE, 1);
      check("wb_adr_hold", RD_ADR, exp_rd);
      check("wb_data_hold", RD_DATA, exp_data);
      check("wb_no_done", INSTR_DONE, 0);
    end
    @(negedge CLK); RD_ACK = (exp_rd != 5'd0); cycle_val = cycle_val + 32'd7;
    #1 check("wb_we", RD_WE, (exp_rd != 5'd0));
    check("wb_adr", RD_ADR, exp_rd);
    check("wb_data", RD_DATA, exp_data);
    check("wb_done", INSTR_DONE, 1);
    check("wb_no_illegal", ILLEGAL, 0);
    @(negedge CLK); RD_ACK = 1'b0;
    #1 check("done_single_pulse", INSTR_DONE, 0);
    check("ready_after_done", REQ_READY, 1);
  endtask

  // Accept, CHECK, then the single TRAP cycle.
  task automatic run_trap(input logic [31:0] instr, input logic [11:0] exp_adr);
    @(negedge CLK); REQ_VALID = 1'b1; INSTR = instr; RD_ACK = 1'b1;
    #1 check("trap_ready_in_idle", REQ_READY, 1);
    @(negedge CLK); REQ_VALID = 1'b0;
    #1 check("trap_csr_adr", CSR_ADR, exp_adr);
    @(negedge CLK);
    #1 check("trap_illegal", ILLEGAL, 1);
    check("trap_no_we", RD_WE, 0);
    check("trap_no_done", INSTR_DONE, 0);
    check("trap_not_ready", REQ_READY, 0);
    @(negedge CLK); RD_ACK = 1'b0;
    #1 check("trap_single_pulse", ILLEGAL, 0);
    check("trap_ready_after", REQ_READY, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RES = 1'b0; REQ_VALID = 1'b0; INSTR = '0; RD_ACK = 1'b0;
    cycle_val = 32'd0; time_val = 32'h0000_1234; instret_val = 32'd42;
    #2 RES = 1'b1;
    repeat (2) @(negedge CLK);
    RES = 1'b0;
    #1 check("rst_ready", REQ_READY, 1);
    check("rst_we", RD_WE, 0);
    check("rst_done", INSTR_DONE, 0);
    check("rst_illegal", ILLEGAL, 0);
    check("rst_csr_adr", CSR_ADR, 12'h000);
    check("rst_rd_adr", RD_ADR, 0);
    check("rst_rd_data", RD_DATA, 0);

    // CSRRS x5,0xC00,x0 with cycle=100: retires at N+2
    cycle_val = 32'd100;
    run_read(32'hC00022F3, 0, 12'hC00, 5'd5, 32'd100);

    // CSRRS x7,0xF14,x0 with ack delayed: RD_WE held 4 cycles, hart ID 3
    run_read(32'hF14023F3, 3, 12'hF14, 5'd7, 32'd3);

    // Snapshot: cycle counter moves during WB, RD_DATA stays at the CHECK value
    cycle_val = 32'd500;
    run_read(32'hC00022F3, 2, 12'hC00, 5'd5, 32'd500);

    // CSRRS x0,0xC02,x0: no register write, still retires
    run_read(32'hC0202073, 0, 12'hC02, 5'd0, 32'd42);

    // Non-SYSTEM opcode and reserved funct3 100 trap in every build
    run_trap(32'h00000013, 12'h000);
    run_trap(32'hC00042F3, 12'hC00);

`ifdef CSR_ACCESS_CHECK_EN
    run_trap(32'hC01110F3, 12'hC01);   // CSRRW x1,0xC01,x2
    run_trap(32'hC000A2F3, 12'hC00);   // CSRRS x5,0xC00,x1
    run_trap(32'h300021F3, 12'h300);   // CSRRS x3,0x300,x0
`else
    run_read(32'hC01110F3, 0, 12'hC01, 5'd1, 32'h0000_1234);
    cycle_val = 32'd77;
    run_read(32'hC000A2F3, 0, 12'hC00, 5'd5, 32'd77);
    run_read(32'h300021F3, 0, 12'h300, 5'd3, 32'd0);
`endif

    // Reset during WB with RD_ACK low drops the instruction
    cycle_val = 32'd9;
    @(negedge CLK); REQ_VALID = 1'b1; INSTR = 32'hC00022F3; RD_ACK = 1'b0;
    @(negedge CLK); REQ_VALID = 1'b0;
    @(negedge CLK);
    #1 check("pre_rst_we", RD_WE, 1);
    #1 RES = 1'b1; RD_ACK = 1'b1;
    #1 check("async_rst_we", RD_WE, 0);
    check("async_rst_done", INSTR_DONE, 0);
    check("async_rst_illegal", ILLEGAL, 0);
    check("async_rst_rd_adr", RD_ADR, 0);
    check("async_rst_rd_data", RD_DATA, 0);
    check("async_rst_csr_adr", CSR_ADR, 12'h000);
    @(negedge CLK); RES = 1'b0; RD_ACK = 1'b0;
    #1 check("post_rst_ready", REQ_READY, 1);
    check("post_rst_done", INSTR_DONE, 0);

    // Back-to-back with REQ_VALID held high and RD_ACK high
    cycle_val = 32'd11;
    @(negedge CLK); REQ_VALID = 1'b1; INSTR = 32'hC00022F3; RD_ACK = 1'b1;
    #1 check("b2b_accept1", REQ_READY, 1);
    @(negedge CLK); INSTR = 32'hC0202073;
    #1 check("b2b_check1_ready", REQ_READY, 0);
    @(negedge CLK);
    #1 check("b2b_done1", INSTR_DONE, 1);
    check("b2b_wb1_ready", REQ_READY, 0);
    check("b2b_wb1_data", RD_DATA, 32'd11);
    @(negedge CLK);
    #1 check("b2b_accept2", REQ_READY, 1);
    check("b2b_idle_no_done", INSTR_DONE, 0);
    @(negedge CLK);
    #1 check("b2b_check2_adr", CSR_ADR, 12'hC02);
    check("b2b_check2_ready", REQ_READY, 0);
    @(negedge CLK);
    #1 check("b2b_done2", INSTR_DONE, 1);
    check("b2b_wb2_we", RD_WE, 0);
    @(negedge CLK); REQ_VALID = 1'b0; RD_ACK = 1'b0;
    #1 check("b2b_ready_end", REQ_READY, 1);
    @(negedge CLK);
    #1 check("b2b_no_third", REQ_READY, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
